// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter for fetch/data requests with registered strobes and one-cycle hit pulses.
// Latency: request-to-hit is N+1 cycles for an N-cycle RAM (minimum 2); one IDLE cycle between accesses.
// Backpressure: requests are levels held until hit; MEMORY_ARBITER_RR_EN enables fetch/data round-robin.
module memory_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              ihit,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dhit,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ramACK
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IBUSY = 3'd1,
        DBUSY = 3'd2,
        IDONE = 3'd3,
        DDONE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   store_q, store_d;
    logic [DATA_W-1:0]   iload_q, iload_d;
    logic [DATA_W-1:0]   dload_q, dload_d;
    logic                ihit_q, ihit_d;
    logic                dhit_q, dhit_d;
    logic                ram_ren_q, ram_ren_d;
    logic                ram_wen_q, ram_wen_d;
    logic                data_req;
    logic                grant_data;

`ifdef MEMORY_ARBITER_RR_EN
    logic                last_was_data_q, last_was_data_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_was_data_q <= 1'b0;
        end else begin
            last_was_data_q <= last_was_data_d;
        end
    end
`endif

    assign data_req = dREN | dWEN;

    // Fetch wins a tie only when the previous grant went to data.
`ifdef MEMORY_ARBITER_RR_EN
    assign grant_data = data_req & ~(iREN & last_was_data_q);
`else
    assign grant_data = data_req;
`endif

    always_comb begin
        state_d  = state_q;
        op_wr_d  = op_wr_q;
        addr_d   = addr_q;
        store_d  = store_q;
        iload_d  = iload_q;
        dload_d  = dload_q;
        ihit_d   = 1'b0;
        dhit_d   = 1'b0;
`ifdef MEMORY_ARBITER_RR_EN
        last_was_data_d = last_was_data_q;
`endif

        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d = DBUSY;
                    addr_d  = daddr;
                    store_d = dstore;
                    op_wr_d = dWEN;
`ifdef MEMORY_ARBITER_RR_EN
                    last_was_data_d = 1'b1;
`endif
                end else if (iREN) begin
                    state_d = IBUSY;
                    addr_d  = iaddr;
                    op_wr_d = 1'b0;
`ifdef MEMORY_ARBITER_RR_EN
                    last_was_data_d = 1'b0;
`endif
                end
            end
            IBUSY: begin
                if (ramACK) begin
                    state_d = IDONE;
                    iload_d = ramload;
                    // A flushed fetch still finishes on the RAM but reports no hit.
                    ihit_d  = iREN;
                end
            end
            DBUSY: begin
                if (ramACK) begin
                    state_d = DDONE;
                    if (!op_wr_q) begin
                        dload_d = ramload;
                    end
                    dhit_d  = data_req;
                end
            end
            IDONE:   state_d = IDLE;
            DDONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes are decoded from the next state so they leave a flop clean.
        ram_ren_d = (state_d == IBUSY) || ((state_d == DBUSY) && !op_wr_d);
        ram_wen_d = (state_d == DBUSY) && op_wr_d;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            op_wr_q   <= 1'b0;
            addr_q    <= '0;
            store_q   <= '0;
            iload_q   <= '0;
            dload_q   <= '0;
            ihit_q    <= 1'b0;
            dhit_q    <= 1'b0;
            ram_ren_q <= 1'b0;
            ram_wen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_wr_q   <= op_wr_d;
            addr_q    <= addr_d;
            store_q   <= store_d;
            iload_q   <= iload_d;
            dload_q   <= dload_d;
            ihit_q    <= ihit_d;
            dhit_q    <= dhit_d;
            ram_ren_q <= ram_ren_d;
            ram_wen_q <= ram_wen_d;
        end
    end

    assign ihit     = ihit_q;
    assign dhit     = dhit_q;
    assign iload    = iload_q;
    assign dload    = dload_q;
    assign ramREN   = ram_ren_q;
    assign ramWEN   = ram_wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed requests, behavioural RAM, queue-based hit scoreboard.
module tb_memory_arbiter;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        ihit;
    logic [31:0] iload;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic        dhit;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload = '0;
    logic        ramACK = 1'b0;

    memory_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dhit(dhit), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramACK(ramACK)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
        logic [31:0] addr;
        int          lat;
        int          strobes;
        logic        wr;
        logic [31:0] store;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          t0 = 0;
    int          ram_lat = 1;
    int          ram_cnt = 0;
    logic [31:0] mem [logic [31:0]];

    int          mcnt = 0;
    logic        saw_ren = 1'b0;
    logic        saw_wen = 1'b0;
    logic [31:0] laddr = '0;
    logic [31:0] lstore = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic is_d, input logic [31:0] data, input logic [31:0] addr,
                                input int lat, input int strobes, input logic wr, input logic [31:0] store);
        exp_t x;
        x.is_d = is_d; x.data = data; x.addr = addr; x.lat = lat;
        x.strobes = strobes; x.wr = wr; x.store = store;
        return x;
    endfunction

    // RAM model: acks in the ram_lat-th consecutive strobe cycle.
    always @(negedge CLK) begin
        if (ramREN || ramWEN) begin
            ram_cnt = ram_cnt + 1;
            ramACK  = (ram_cnt >= ram_lat);
            ramload = mem.exists(ramaddr) ? mem[ramaddr] : 32'h0;
            if (ramACK && ramWEN) mem[ramaddr] = ramstore;
        end else begin
            ram_cnt = 0;
            ramACK  = 1'b0;
        end
    end

    // Monitor: every hit pops one expectation.
    always @(negedge CLK) begin
        if (ihit || dhit) begin
            chk("hit_exclusive", {63'd0, ihit & dhit}, 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_hit ihit=%0b dhit=%0b required none", ihit, dhit);
            end else begin
                e = exp_q.pop_front();
                chk("hit_kind", {63'd0, dhit}, {63'd0, e.is_d});
                chk("hit_data", e.is_d ? dload : iload, e.data);
                chk("hit_latency", cyc - t0, e.lat);
                chk("strobe_cycles", mcnt, e.strobes);
                chk("ram_addr", laddr, e.addr);
                chk("ram_wen_seen", {63'd0, saw_wen}, {63'd0, e.wr});
                chk("ram_ren_seen", {63'd0, saw_ren}, {63'd0, ~e.wr});
                if (e.wr) chk("ram_store", lstore, e.store);
            end
            mcnt = 0; saw_ren = 1'b0; saw_wen = 1'b0;
        end else if (ramREN || ramWEN) begin
            mcnt++;
            saw_ren = saw_ren | ramREN;
            saw_wen = saw_wen | ramWEN;
            laddr   = ramaddr;
            lstore  = ramstore;
        end else begin
            mcnt = 0; saw_ren = 1'b0; saw_wen = 1'b0;
        end
    end

    // Drops each request on its hit; bounded.
    task automatic wait_done();
        int n;
        n = 0;
        while ((iREN || dREN || dWEN) && n < 200) begin
            @(negedge CLK);
            if (dhit) begin dREN = 1'b0; dWEN = 1'b0; end
            if (ihit) iREN = 1'b0;
            n++;
        end
        chk("requests_served", {63'd0, iREN | dREN | dWEN}, 64'd0);
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ramREN"}, {63'd0, ramREN}, 64'd0);
        chk({tag, "_ramWEN"}, {63'd0, ramWEN}, 64'd0);
        chk({tag, "_ramaddr"}, ramaddr, 64'd0);
        chk({tag, "_ramstore"}, ramstore, 64'd0);
        chk({tag, "_ihit"}, {63'd0, ihit}, 64'd0);
        chk({tag, "_dhit"}, {63'd0, dhit}, 64'd0);
        chk({tag, "_iload"}, iload, 64'd0);
        chk({tag, "_dload"}, dload, 64'd0);
    endtask

    initial begin
        int n;
        mem[32'h40]  = 32'h8C220004;
        mem[32'h80]  = 32'h55AA55AA;
        mem[32'h100] = 32'h11112222;
        mem[32'h44]  = 32'h33334444;
        mem[32'h48]  = 32'h00000077;
        mem[32'h4C]  = 32'hABCD0123;

        #1 nRST = 1'b0;
        #10;
        chk_all_zero("reset");
        @(negedge CLK) nRST = 1'b1;
        @(negedge CLK);

        // Single fetch, 3-cycle RAM
        ram_lat = 3;
        exp_q.push_back(mk(1'b0, 32'h8C220004, 32'h40, 4, 3, 1'b0, 32'h0));
        iaddr = 32'h40; iREN = 1'b1; t0 = cyc;
        wait_done();

        // Data read, 2-cycle RAM (also primes the round-robin flag)
        ram_lat = 2;
        exp_q.push_back(mk(1'b1, 32'h55AA55AA, 32'h80, 3, 2, 1'b0, 32'h0));
        daddr = 32'h80; dREN = 1'b1; t0 = cyc;
        wait_done();

        // Simultaneous fetch and data read, 1-cycle RAM
        ram_lat = 1;
`ifdef MEMORY_ARBITER_RR_EN
        exp_q.push_back(mk(1'b0, 32'h33334444, 32'h44, 2, 1, 1'b0, 32'h0));
        exp_q.push_back(mk(1'b1, 32'h11112222, 32'h100, 5, 1, 1'b0, 32'h0));
`else
        exp_q.push_back(mk(1'b1, 32'h11112222, 32'h100, 2, 1, 1'b0, 32'h0));
        exp_q.push_back(mk(1'b0, 32'h33334444, 32'h44, 5, 1, 1'b0, 32'h0));
`endif
        iaddr = 32'h44; daddr = 32'h100; iREN = 1'b1; dREN = 1'b1; t0 = cyc;
        wait_done();

        // Read+write conflict resolves to write; dload keeps previous read
        exp_q.push_back(mk(1'b1, 32'h11112222, 32'h200, 2, 1, 1'b1, 32'hDEADBEEF));
        daddr = 32'h200; dstore = 32'hDEADBEEF; dREN = 1'b1; dWEN = 1'b1; t0 = cyc;
        wait_done();

        // Read back the written word
        exp_q.push_back(mk(1'b1, 32'hDEADBEEF, 32'h200, 2, 1, 1'b0, 32'h0));
        daddr = 32'h200; dREN = 1'b1; t0 = cyc;
        wait_done();

        // Flushed fetch: no hit, IDLE two cycles after the ack
        ram_lat = 3;
        iaddr = 32'h48; iREN = 1'b1; t0 = cyc;
        @(negedge CLK);
        iREN = 1'b0;
        n = 0;
        do begin
            @(posedge CLK);
            n++;
        end while (!ramACK && n < 50);
        chk("flush_ack_seen", {63'd0, ramACK}, 64'd1);
        @(negedge CLK);
        chk("flush_no_ihit", {63'd0, ihit}, 64'd0);
        chk("flush_strobe_low", {63'd0, ramREN}, 64'd0);
        ram_lat = 1;
        exp_q.push_back(mk(1'b0, 32'hABCD0123, 32'h4C, 3, 1, 1'b0, 32'h0));
        iaddr = 32'h4C; iREN = 1'b1; t0 = cyc;
        wait_done();

        // Reset in the middle of a long write
        ram_lat = 20;
        daddr = 32'h300; dstore = 32'hCAFEF00D; dWEN = 1'b1;
        repeat (3) @(negedge CLK);
        chk("busy_ramWEN", {63'd0, ramWEN}, 64'd1);
        chk("busy_ramaddr", ramaddr, 64'h300);
        #1 nRST = 1'b0;
        #1;
        chk_all_zero("midreset");
        dWEN = 1'b0;
        @(negedge CLK) nRST = 1'b1;
        repeat (10) @(negedge CLK);
        chk("abandoned_not_written", {63'd0, mem.exists(32'h300)}, 64'd0);
        chk("all_hits_seen", exp_q.size(), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
